// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared constants, field positions and FSM encoding for the alarm scheduler
package rtc_pkg;

    localparam int NUM_SLOTS = 4;
    localparam int SLOT_W    = 29;

    // wr_data / slot record layout
    localparam int WR_EN_BIT   = 28;
    localparam int WR_HOUR_LSB = 20;
    localparam int WR_MIN_LSB  = 12;
    localparam int WR_DAY_LSB  = 4;
    localparam int WR_WDAY_LSB = 0;

    // full_time layout
    localparam int TIME_HOUR_LSB = 16;
    localparam int TIME_MIN_LSB  = 8;
    localparam int TIME_SEC_LSB  = 0;

    // full_cal layout
    localparam int CAL_DAY_LSB   = 28;
    localparam int CAL_WDAY_LSB  = 24;
    localparam int CAL_MONTH_LSB = 16;
    localparam int CAL_YEAR_LSB  = 0;

    // Wildcards: a slot with these values matches any day / weekday
    localparam logic [7:0] DAY_ANY  = 8'h00;
    localparam logic [3:0] WDAY_ANY = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_WAIT_ACK = 2'd2
    } state_e;

endpackage

// File: rtl/alarm_match.sv
// rtl/alarm_match.sv - combinational compare of one alarm slot against the current time/calendar
module alarm_match
    import rtc_pkg::*;
(
    input  logic [SLOT_W-1:0] slot_cfg,
    input  logic [7:0]        cur_hour,
    input  logic [7:0]        cur_min,
    input  logic [7:0]        cur_day,
    input  logic [3:0]        cur_wday,
    output logic              match
);

    logic       cfg_en;
    logic [7:0] cfg_hour;
    logic [7:0] cfg_min;
    logic [7:0] cfg_day;
    logic [3:0] cfg_wday;
    logic       day_ok;
    logic       wday_ok;

    assign cfg_en   = slot_cfg[WR_EN_BIT];
    assign cfg_hour = slot_cfg[WR_HOUR_LSB +: 8];
    assign cfg_min  = slot_cfg[WR_MIN_LSB +: 8];
    assign cfg_day  = slot_cfg[WR_DAY_LSB +: 8];
    assign cfg_wday = slot_cfg[WR_WDAY_LSB +: 4];

    assign day_ok  = (cfg_day == DAY_ANY) || (cfg_day == cur_day);
    assign wday_ok = (cfg_wday == WDAY_ANY) || (cfg_wday == cur_wday);

    assign match = cfg_en && (cfg_hour == cur_hour) && (cfg_min == cur_min) && day_ok && wday_ok;

endmodule

// File: rtl/alarm_scheduler.sv
// rtl/alarm_scheduler.sv - multi-slot RTC alarm matcher with pending/missed tracking and irq/ack handshake
module alarm_scheduler #(
    parameter int NUM_SLOTS = rtc_pkg::NUM_SLOTS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [23:0]          full_time,
    input  logic [35:0]          full_cal,
    input  logic                 wr_en,
    input  logic [1:0]           wr_slot,
    input  logic [28:0]          wr_data,
    input  logic [1:0]           rd_slot,
    output logic [28:0]          rd_data,
    output logic                 irq,
    output logic [1:0]           irq_slot,
    input  logic                 ack,
    output logic [NUM_SLOTS-1:0] pending,
    output logic [NUM_SLOTS-1:0] missed
);

    import rtc_pkg::*;

    logic [SLOT_W-1:0]    slot_q [NUM_SLOTS];
    logic [SLOT_W-1:0]    slot_d [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] pending_q, pending_d;
    logic [NUM_SLOTS-1:0] missed_q, missed_d;
    logic [7:0]           prev_sec_q, prev_sec_d;
    logic [SLOT_W-1:0]    rd_data_q, rd_data_d;

    state_e               state_q, state_d;
    logic                 irq_q, irq_d;
    logic [1:0]           irq_slot_q, irq_slot_d;

    logic                 tick;
    logic [NUM_SLOTS-1:0] match;
    logic [NUM_SLOTS-1:0] wr_mask;
    logic [NUM_SLOTS-1:0] ack_hit;
    logic [NUM_SLOTS-1:0] pending_avail;
    logic [1:0]           lowest_idx;
    logic                 slot_rewritten;
    logic                 unused_cal;

    // Month and year never take part in a match
    assign unused_cal = ^full_cal[CAL_YEAR_LSB +: 24];

    // A minute starts on the first cycle that seconds wrap to zero
    assign tick = (full_time[TIME_SEC_LSB +: 8] == 8'd0) && (prev_sec_q != 8'd0);

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_match
        alarm_match u_match (
            .slot_cfg (slot_q[g]),
            .cur_hour (full_time[TIME_HOUR_LSB +: 8]),
            .cur_min  (full_time[TIME_MIN_LSB +: 8]),
            .cur_day  (full_cal[CAL_DAY_LSB +: 8]),
            .cur_wday (full_cal[CAL_WDAY_LSB +: 4]),
            .match    (match[g])
        );
    end

    // Per-slot decode of this cycle's write and accepted acknowledge
    always_comb begin
        wr_mask = '0;
        ack_hit = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            wr_mask[i] = wr_en && (wr_slot == 2'(i));
            ack_hit[i] = (state_q == ST_WAIT_ACK) && ack && (irq_slot_q == 2'(i));
        end
    end

    // Slot storage and pending/missed bookkeeping: write beats match, match beats ack
    always_comb begin
        slot_d     = slot_q;
        pending_d  = pending_q;
        missed_d   = missed_q;
        prev_sec_d = full_time[TIME_SEC_LSB +: 8];
        rd_data_d  = slot_q[rd_slot];
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (wr_mask[i]) begin
                slot_d[i]    = wr_data;
                pending_d[i] = 1'b0;
                missed_d[i]  = 1'b0;
            end else if (tick && match[i]) begin
                // A match arriving together with its own ack is a fresh event, not an overrun
                if (pending_q[i] && !ack_hit[i]) begin
                    missed_d[i] = 1'b1;
                end
                pending_d[i] = 1'b1;
            end else if (ack_hit[i]) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    // Lowest-index pending slot, ignoring any slot being rewritten this cycle
    always_comb begin
        pending_avail = pending_q & ~wr_mask;
        lowest_idx    = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pending_avail[i]) begin
                lowest_idx = 2'(i);
            end
        end
    end

    assign slot_rewritten = wr_en && (wr_slot == irq_slot_q);

    // Interrupt FSM next-state: issue lowest pending, hold until ack or the slot is rewritten
    always_comb begin
        state_d    = state_q;
        irq_d      = irq_q;
        irq_slot_d = irq_slot_q;
        case (state_q)
            ST_IDLE: begin
                if (|pending_avail) begin
                    state_d    = ST_ISSUE;
                    irq_d      = 1'b1;
                    irq_slot_d = lowest_idx;
                end
            end
            ST_ISSUE: begin
                if (slot_rewritten) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (slot_rewritten || ack) begin
                    state_d = ST_IDLE;
                    irq_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                irq_d   = 1'b0;
            end
        endcase
    end

    // Slot, status and readback registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                slot_q[i] <= '0;
            end
            pending_q  <= '0;
            missed_q   <= '0;
            prev_sec_q <= 8'd0;
            rd_data_q  <= '0;
        end else begin
            slot_q     <= slot_d;
            pending_q  <= pending_d;
            missed_q   <= missed_d;
            prev_sec_q <= prev_sec_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Interrupt FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            irq_q      <= 1'b0;
            irq_slot_q <= 2'd0;
        end else begin
            state_q    <= state_d;
            irq_q      <= irq_d;
            irq_slot_q <= irq_slot_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign irq      = irq_q;
    assign irq_slot = irq_slot_q;
    assign pending  = pending_q;
    assign missed   = missed_q;

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameter NUM_SLOTS, default 4, number of independent alarm slots.
REQ-002 clk  in  1  system clock, same domain as the divided RTC clock consumer.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 full_time  in  24  current time, hour[23:16] min[15:8] sec[7:0], binary.
REQ-005 full_cal  in  36  current calendar, day[35:28] weekday[27:24] month[23:16] year[15:0].
REQ-006 wr_en  in  1  one-cycle slot write strobe.
REQ-007 wr_slot  in  2  slot index for write.
REQ-008 wr_data  in  29  enable[28], hour[27:20], min[19:12], day[11:4], weekday[3:0].
REQ-009 rd_slot  in  2  slot index for readback.
REQ-010 rd_data  out  29  registered readback of slot rd_slot, wr_data format.
REQ-011 irq  out  1  alarm request, level, held until acknowledged.
REQ-012 irq_slot  out  2  slot being signalled; valid while irq=1.
REQ-013 ack  in  1  one-cycle acknowledge of the signalled slot.
REQ-014 pending  out  NUM_SLOTS  matched, not yet acknowledged.
REQ-015 missed  out  NUM_SLOTS  sticky: slot matched again while still pending.

Function
REQ-016 Minute tick: register prev_sec; tick=1 in cycle where sec==0 and prev_sec!=0.
REQ-017 Slot match: enable=1, hour==full_time hour, min==full_time min, (day==0 or day==full_cal day), (weekday==4'hF or weekday==full_cal weekday).
REQ-018 On tick, pending[i] set at next clock edge for every matching slot i.
REQ-019 Match on slot already pending: pending stays 1, missed[i] set.
REQ-020 Write: slot fields updated at the wr_en edge; pending[i] and missed[i] cleared for that slot.
REQ-021 FSM states IDLE, ISSUE, WAIT_ACK.
REQ-022 IDLE: any pending -> ISSUE, latching lowest-index pending slot into irq_slot.
REQ-023 ISSUE: irq=1 asserted -> WAIT_ACK next cycle.
REQ-024 WAIT_ACK: ack=1 -> clear pending[irq_slot], irq=0 next cycle, -> IDLE.
REQ-025 Latency: tick cycle N -> pending visible N+1 -> irq visible N+2.
REQ-026 ack outside WAIT_ACK ignored, no state change.
REQ-027 ack and new match of same slot in same cycle: set wins; pending stays 1, missed unchanged.
REQ-028 Write to irq_slot during ISSUE/WAIT_ACK: irq drops next cycle, FSM -> IDLE, no ack needed.
REQ-029 irq_slot stable for the whole irq=1 interval.
REQ-030 rd_data = slot contents one cycle after rd_slot applied; reflects a same-cycle write one cycle later.
REQ-031 Tick coincident with wr_en to same slot: write wins, pending not set.

Reset
REQ-032 rst=1 asynchronously: all slots zero (disabled), pending=0, missed=0, prev_sec=0, FSM=IDLE, irq=0, irq_slot=0, rd_data=0.
REQ-033 Reset mid-WAIT_ACK: irq drops immediately, no pending retained.
REQ-034 Release with sec==0: no tick until sec leaves and returns to 0.

Structure
REQ-035 Shared package rtc_pkg: NUM_SLOTS, field bit positions of wr_data/full_time/full_cal, DAY_ANY=8'h00, WDAY_ANY=4'hF, FSM state encodings.
REQ-036 One sub-module alarm_match, instantiated per slot: combinational slot-vs-current comparison returning match.

Verification
REQ-037 Slot0 = 07:30 any day/any weekday enabled; time 07:29:59 -> 07:30:00 -> pending=0001 at N+1, irq=1 irq_slot=0 at N+2; ack -> irq=0, pending=0000.
REQ-038 Slots 1 and 3 both 12:00; tick -> pending=1010; irq_slot=1 first; after ack irq_slot=3 within 2 cycles.
REQ-039 Slot2 = 08:00 day 15 weekday 2; cal day 15 weekday 3 -> no pending; weekday 2 -> pending[2]=1.
REQ-040 Slot0 pending, unacked; time advances to next matching minute (min changes back via re-write of time) -> missed=0001, pending=0001.
REQ-041 irq=1 on slot0, write slot0 with enable=0 -> irq=0 next cycle, pending=0000, missed=0000, FSM IDLE.
REQ-042 rst pulse during WAIT_ACK -> irq=0 same cycle, rd_data of any slot=0, released with sec=0 -> no irq.
